// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the fetch/decode/execute-writeback core:
// sequencer state encodings, register-file geometry and the NOP word.
package cpu_ctrl_pkg;

    localparam int unsigned REG_AW   = 5;
    localparam int unsigned NUM_REGS = 32;

    // addi x0, x0, 0 -- loaded by the flush and bubble consumers
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/hazard_controller_scoreboard.sv
// Busy-bit scoreboard: one bit per architectural register with a pending write.
module hazard_controller_scoreboard #(
    parameter int unsigned NUM_REGS = cpu_ctrl_pkg::NUM_REGS,
    parameter int unsigned REG_AW   = cpu_ctrl_pkg::REG_AW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                set_en_i,
    input  logic [REG_AW-1:0]   set_sel_i,
    input  logic                clr_en_i,
    input  logic [REG_AW-1:0]   clr_sel_i,
    output logic [NUM_REGS-1:0] busy_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Clear is applied before set so a same-cycle set of the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) begin
            busy_d[clr_sel_i] = 1'b0;
        end
        if (set_en_i && (set_sel_i != '0)) begin
            busy_d[set_sel_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencer: RAW hazard stall against the scoreboard, wrong-path
// squash after redirect, PC/pipeline-register enables and a stall counter.
module hazard_controller #(
    parameter int unsigned NUM_REGS     = cpu_ctrl_pkg::NUM_REGS,
    parameter int unsigned REG_AW       = cpu_ctrl_pkg::REG_AW,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                dec_valid,
    input  logic [REG_AW-1:0]   dec_rs1_sel,
    input  logic                dec_rs1_used,
    input  logic [REG_AW-1:0]   dec_rs2_sel,
    input  logic                dec_rs2_used,
    input  logic [REG_AW-1:0]   dec_rd_sel,
    input  logic                dec_write_enable,
    input  logic                wb_valid,
    input  logic [REG_AW-1:0]   wb_rd_sel,
    input  logic                redirect,
    output logic                pc_stall,
    output logic                if_id_stall,
    output logic                if_id_flush,
    output logic                id_ex_bubble,
    output logic                issue,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic [1:0]          ctrl_state,
    output logic [CNT_W-1:0]    stall_count
);
    import cpu_ctrl_pkg::*;

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

    ctrl_state_e      state_q;
    logic [2:0]       flush_cnt_q;
    logic [CNT_W-1:0] stall_count_q;
    logic             hazard_rs1;
    logic             hazard_rs2;
    logic             hazard;

    // Same-cycle writeback to the source is covered by operand forwarding.
    assign hazard_rs1 = dec_rs1_used && (dec_rs1_sel != '0) && busy_vec[dec_rs1_sel]
                        && !(wb_valid && (wb_rd_sel == dec_rs1_sel));
    assign hazard_rs2 = dec_rs2_used && (dec_rs2_sel != '0) && busy_vec[dec_rs2_sel]
                        && !(wb_valid && (wb_rd_sel == dec_rs2_sel));
    assign hazard     = dec_valid && (hazard_rs1 || hazard_rs2);

    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        issue        = 1'b0;
        if (redirect || (state_q == ST_FLUSH)) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (hazard) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
        end else begin
            issue = dec_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            flush_cnt_q   <= '0;
            stall_count_q <= '0;
        end else if (redirect) begin
            flush_cnt_q <= FLUSH_RELOAD;
            state_q     <= (FLUSH_RELOAD == '0) ? ST_RUN : ST_FLUSH;
        end else if (state_q == ST_FLUSH) begin
            // Leave FLUSH on the cycle the counter reaches zero.
            flush_cnt_q <= (flush_cnt_q == '0) ? '0 : flush_cnt_q - 3'd1;
            state_q     <= (flush_cnt_q <= 3'd1) ? ST_RUN : ST_FLUSH;
        end else if (hazard) begin
            state_q <= ST_STALL;
            if (stall_count_q != '1) begin
                stall_count_q <= stall_count_q + 1'b1;
            end
        end else begin
            state_q <= ST_RUN;
        end
    end

    hazard_controller_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .REG_AW   (REG_AW)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_en_i  (issue && dec_write_enable),
        .set_sel_i (dec_rd_sel),
        .clr_en_i  (wb_valid),
        .clr_sel_i (wb_rd_sel),
        .busy_o    (busy_vec)
    );

    assign ctrl_state  = state_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: stall, bypass, x0, flush, set-wins,
// counter saturation and asynchronous reset.
module tb_hazard_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dec_valid;
    logic [4:0]  dec_rs1_sel;
    logic        dec_rs1_used;
    logic [4:0]  dec_rs2_sel;
    logic        dec_rs2_used;
    logic [4:0]  dec_rd_sel;
    logic        dec_write_enable;
    logic        wb_valid;
    logic [4:0]  wb_rd_sel;
    logic        redirect;
    logic        pc_stall;
    logic        if_id_stall;
    logic        if_id_flush;
    logic        id_ex_bubble;
    logic        issue;
    logic [31:0] busy_vec;
    logic [1:0]  ctrl_state;
    logic [15:0] stall_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_controller #(
        .NUM_REGS     (32),
        .REG_AW       (5),
        .FLUSH_CYCLES (2),
        .CNT_W        (16)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .dec_valid        (dec_valid),
        .dec_rs1_sel      (dec_rs1_sel),
        .dec_rs1_used     (dec_rs1_used),
        .dec_rs2_sel      (dec_rs2_sel),
        .dec_rs2_used     (dec_rs2_used),
        .dec_rd_sel       (dec_rd_sel),
        .dec_write_enable (dec_write_enable),
        .wb_valid         (wb_valid),
        .wb_rd_sel        (wb_rd_sel),
        .redirect         (redirect),
        .pc_stall         (pc_stall),
        .if_id_stall      (if_id_stall),
        .if_id_flush      (if_id_flush),
        .id_ex_bubble     (id_ex_bubble),
        .issue            (issue),
        .busy_vec         (busy_vec),
        .ctrl_state       (ctrl_state),
        .stall_count      (stall_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        dec_valid = 0; dec_rs1_sel = 0; dec_rs1_used = 0; dec_rs2_sel = 0; dec_rs2_used = 0;
        dec_rd_sel = 0; dec_write_enable = 0; wb_valid = 0; wb_rd_sel = 0; redirect = 0;
    endtask

    task automatic dec(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                       input logic u2, input logic [4:0] rd, input logic we);
        dec_valid = 1; dec_rs1_sel = rs1; dec_rs1_used = u1; dec_rs2_sel = rs2;
        dec_rs2_used = u2; dec_rd_sel = rd; dec_write_enable = we;
    endtask

    initial begin
        rst_n = 0;
        idle();
        #3;
        check("rst_busy", busy_vec, 32'h0);
        check("rst_state", {30'b0, ctrl_state}, 32'd0);
        check("rst_cnt", {16'b0, stall_count}, 32'd0);
        check("rst_ctrl", {27'b0, pc_stall, if_id_stall, if_id_flush, id_ex_bubble, issue}, 32'h0);
        @(negedge clk); rst_n = 1;

        // addi x5 issues
        dec(5'd0, 0, 5'd0, 0, 5'd5, 1); #1;
        check("addi_issue", {31'b0, issue}, 32'd1);
        check("addi_nostall", {31'b0, pc_stall}, 32'd0);
        @(negedge clk);
        check("addi_busy", busy_vec, 32'h0000_0020);

        // RAW on x5, no writeback
        dec(5'd5, 1, 5'd0, 0, 5'd6, 1); #1;
        check("raw_stall", {29'b0, pc_stall, if_id_stall, id_ex_bubble}, 32'h7);
        check("raw_noissue", {31'b0, issue}, 32'd0);
        @(negedge clk);
        check("raw_state", {30'b0, ctrl_state}, 32'd1);
        check("raw_cnt", {16'b0, stall_count}, 32'd1);
        check("raw_busy", busy_vec, 32'h0000_0020);

        // writeback of x5 arrives: bypass releases the stall
        wb_valid = 1; wb_rd_sel = 5'd5; #1;
        check("wb_issue", {31'b0, issue}, 32'd1);
        check("wb_nostall", {31'b0, pc_stall}, 32'd0);
        @(negedge clk);
        check("wb_busy", busy_vec, 32'h0000_0040);
        check("wb_state", {30'b0, ctrl_state}, 32'd0);
        check("wb_cnt", {16'b0, stall_count}, 32'd1);

        // rs2 bypass on x6, destination x0
        dec(5'd0, 0, 5'd6, 1, 5'd0, 1); wb_valid = 1; wb_rd_sel = 5'd6; #1;
        check("rs2_byp_issue", {31'b0, issue}, 32'd1);
        check("rs2_byp_nostall", {31'b0, pc_stall}, 32'd0);
        @(negedge clk);
        check("x0_busy", busy_vec, 32'h0);

        // issue rd=7, then set/clear x7 in the same cycle; x0 reads never stall
        wb_valid = 0; dec(5'd0, 1, 5'd0, 1, 5'd7, 1); #1;
        check("x0_read_issue", {31'b0, issue}, 32'd1);
        @(negedge clk);
        check("x7_busy", busy_vec, 32'h0000_0080);
        wb_valid = 1; wb_rd_sel = 5'd7; #1;
        check("setclr_issue", {31'b0, issue}, 32'd1);
        @(negedge clk);
        check("setclr_busy", busy_vec, 32'h0000_0080);

        // stall on x7, then redirect from STALL
        wb_valid = 0; dec(5'd7, 1, 5'd0, 0, 5'd0, 0); #1;
        check("x7_stall", {31'b0, pc_stall}, 32'd1);
        @(negedge clk);
        check("x7_state", {30'b0, ctrl_state}, 32'd1);
        check("x7_cnt", {16'b0, stall_count}, 32'd2);
        redirect = 1; #1;
        check("redir_ctrl", {27'b0, pc_stall, if_id_stall, if_id_flush, id_ex_bubble, issue}, 32'h6);
        @(negedge clk);
        check("redir_state", {30'b0, ctrl_state}, 32'd2);
        check("redir_cnt", {16'b0, stall_count}, 32'd2);
        redirect = 0; #1;
        check("flush2_ctrl", {27'b0, pc_stall, if_id_stall, if_id_flush, id_ex_bubble, issue}, 32'h6);
        @(negedge clk);
        dec_valid = 0; #1;
        check("flush_end_state", {30'b0, ctrl_state}, 32'd0);
        check("flush_end_flush", {31'b0, if_id_flush}, 32'd0);

        // redirect, re-redirect in cycle 2, flush extends to cycle 3
        redirect = 1; #1;
        check("rr_c1_flush", {31'b0, if_id_flush}, 32'd1);
        @(negedge clk);
        check("rr_c2_state", {30'b0, ctrl_state}, 32'd2);
        #1;
        check("rr_c2_flush", {31'b0, if_id_flush}, 32'd1);
        @(negedge clk);
        redirect = 0; #1;
        check("rr_c3_state", {30'b0, ctrl_state}, 32'd2);
        check("rr_c3_flush", {31'b0, if_id_flush}, 32'd1);
        @(negedge clk); #1;
        check("rr_end_state", {30'b0, ctrl_state}, 32'd0);
        check("rr_end_flush", {31'b0, if_id_flush}, 32'd0);

        // long hazard on x7 saturates the counter
        dec(5'd7, 1, 5'd0, 0, 5'd0, 0);
        for (int i = 0; i < 70000; i++) @(negedge clk);
        #1;
        check("sat_cnt", {16'b0, stall_count}, 32'h0000_FFFF);
        check("sat_state", {30'b0, ctrl_state}, 32'd1);
        check("sat_busy", busy_vec, 32'h0000_0080);

        // asynchronous reset mid-stall, away from any clock edge
        #2; rst_n = 0; #1;
        check("arst_busy", busy_vec, 32'h0);
        check("arst_state", {30'b0, ctrl_state}, 32'd0);
        check("arst_cnt", {16'b0, stall_count}, 32'd0);
        check("arst_stall", {29'b0, pc_stall, if_id_stall, if_id_flush}, 32'd0);
        idle(); #1;
        check("arst_ctrl", {27'b0, pc_stall, if_id_stall, if_id_flush, id_ex_bubble, issue}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
Scoreboard-based pipeline sequencer for the three-stage fetch/decode/execute-writeback CPU core. Tracks in-flight destination registers and stalls decode on RAW hazards that writeback bypass cannot cover. Squashes wrong-path instructions after a taken redirect. Drives the stall and flush enables of the program counter and the pipeline registers, and keeps a stall performance counter.

Parameters:
NUM_REGS, 32, architectural register count; x0 is hard-wired zero.
REG_AW, 5, register select width.
FLUSH_CYCLES, 2, number of cycles fetch/decode are squashed after a redirect; range 1..7.
CNT_W, 16, stall counter width.

Ports:
clk  input  1  core clock; all state updates on the rising edge.
rst_n  input  1  reset, asynchronous and active-low.
dec_valid  input  1  decode stage holds a real instruction.
dec_rs1_sel  input  REG_AW  rs1 select of the decode instruction.
dec_rs1_used  input  1  the decode instruction reads rs1.
dec_rs2_sel  input  REG_AW  rs2 select of the decode instruction.
dec_rs2_used  input  1  the decode instruction reads rs2.
dec_rd_sel  input  REG_AW  destination of the decode instruction.
dec_write_enable  input  1  the decode instruction writes rd.
wb_valid  input  1  the writeback stage writes the register file this cycle.
wb_rd_sel  input  REG_AW  writeback destination.
redirect  input  1  the execute stage resolved a taken branch or jump this cycle.
pc_stall  output  1  hold the program counter.
if_id_stall  output  1  hold the instruction pipeline register.
if_id_flush  output  1  load a NOP into the instruction pipeline register.
id_ex_bubble  output  1  load a NOP (write_enable=0) into the decode pipeline register.
issue  output  1  the decode instruction advances this cycle.
busy_vec  output  NUM_REGS  scoreboard, with bit i set while register i has a pending write.
ctrl_state  output  2  FSM state: 0 RUN, 1 STALL, 2 FLUSH.
stall_count  output  CNT_W  saturating count of STALL cycles.

Behaviour:
- Reset, asynchronous on rst_n low:
  - busy_vec=0, state RUN, flush counter 0, stall_count=0.
  - Combinational outputs then evaluate to pc_stall=if_id_stall=if_id_flush=id_ex_bubble=issue=0.
  - Reset asserted mid-stall or mid-flush abandons the operation immediately. No pending write survives.
- hazard_rsN = dec_rsN_used && dec_rsN_sel!=0 && busy_vec[dec_rsN_sel] && !(wb_valid && wb_rd_sel==dec_rsN_sel).
  - The last term is the same-cycle writeback bypass, which the operand forwarding path covers.
- hazard = dec_valid && (hazard_rs1 || hazard_rs2).
- All control outputs are combinational from the current state and inputs, with zero-cycle latency.
- Priority is redirect > FLUSH > hazard > issue.
- State RUN or STALL:
  - redirect=1: if_id_flush=1, id_ex_bubble=1, issue=0. Next state is FLUSH with counter=FLUSH_CYCLES-1. If FLUSH_CYCLES=1, next state is RUN.
  - Else, hazard=1: pc_stall=if_id_stall=id_ex_bubble=1, issue=0. Next state is STALL, and stall_count increments, saturating at all-ones.
  - Else: issue=dec_valid. Next state is RUN.
- State FLUSH:
  - if_id_flush=1, id_ex_bubble=1, issue=0, pc_stall=0.
  - The counter decrements each cycle. At 0 the next state is RUN.
  - A redirect during FLUSH reloads the counter to FLUSH_CYCLES-1.
- Scoreboard update each edge:
  - Clear busy[wb_rd_sel] if wb_valid.
  - Set busy[dec_rd_sel] if issue && dec_write_enable && dec_rd_sel!=0.
  - Set and clear of the same register in the same cycle: set wins, because the newer producer owns the register.
  - busy[0] is never set.
- Squashed instructions never issue, so they never touch the scoreboard. Already-issued instructions still drain and clear their bits.
- wb_valid for a register that is not busy is legal and a no-op.

Decomposition:
- Shared package cpu_ctrl_pkg:
  - State encodings RUN/STALL/FLUSH.
  - REG_AW and NUM_REGS constants.
  - NOP encoding 32'h00000013 used by the flush and bubble consumers.
- One natural sub-module: scoreboard, holding the busy vector plus set/clear logic. The FSM and the hazard compare stay in the top module.

Test Plan:
- Issue "addi x5" (rd=5, we=1), then next cycle decode reads rs1=5 with no writeback → pc_stall=1, id_ex_bubble=1, ctrl_state=1, stall_count=1. When wb_valid with wb_rd_sel=5 arrives: issue=1 that cycle, busy_vec[5]=0 then re-set only if the new instruction writes x5.
- Decode reads rs2=5 while busy[5]=1 and wb_valid with wb_rd_sel=5 in the same cycle → no stall, issue=1.
- Instruction with rd=0, we=1 issues → busy_vec stays 0. A later read of x0 → no stall.
- redirect=1 while in STALL, FLUSH_CYCLES=2 → if_id_flush=1 for 2 consecutive cycles, issue=0, state returns to RUN. A second redirect in cycle 2 extends the flush to cycle 3.
- Same cycle: issue with rd=7, we=1 and wb_valid with wb_rd_sel=7 → busy_vec[7]=1 after the edge.
- Force 70000 consecutive hazard cycles with CNT_W=16 → stall_count saturates at 16'hFFFF. rst_n pulsed low mid-stall → all outputs and busy_vec go to 0 without waiting for a clock edge.
